// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared constants, FSM encoding and entry layout for the fetch queue
package if_fetch_queue_pkg;

  localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous FIFO with clear, occupancy count and registered head
module if_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clear) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage: one outstanding imem request, {pc,instr} queue to ID
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int                 DEPTH     = 2,
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(IF_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               flush,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fq_state_e       state_q, state_d;
  logic [PC_W-1:0] pending_pc_q, pending_pc_d;
  logic [CW-1:0]   count;
  entry_t          head, push_entry;
  logic            issue, push, pop;

  // Issue only from IDLE, so count alone covers the one-outstanding slot reservation.
  assign issue = !rst && (state_q == FQ_IDLE) && pc_valid && !flush && (count < CW'(DEPTH));
  assign push  = (state_q == FQ_WAIT) && imem_rvalid && !flush;
  assign pop   = id_valid && id_ready;

  assign push_entry = '{pc: pending_pc_q, instr: imem_rdata};

  always_comb begin
    state_d      = state_q;
    pending_pc_d = issue ? pc_in : pending_pc_q;
    case (state_q)
      FQ_IDLE: if (issue) state_d = FQ_WAIT;
      FQ_WAIT: begin
        if (imem_rvalid)  state_d = FQ_IDLE;
        else if (flush)   state_d = FQ_DROP;
      end
      FQ_DROP: if (imem_rvalid) state_d = FQ_IDLE;
      default: state_d = FQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FQ_IDLE;
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  if_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign pc_ready  = issue;
  assign imem_req  = issue;
  assign imem_addr = issue ? pc_in : '0;
  assign id_valid  = (count != '0);
  assign id_pc     = id_valid ? head.pc : '0;
  assign id_instr  = id_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed self-checking bench for if_fetch_queue
module tb_if_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_instr    (id_instr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_in = 32'd7; pc_valid = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    flush = 1'b0; id_ready = 1'b0;
    #12;
    total++; if (pc_ready !== 1'b0) begin bad++; $display("FAIL rst_pc_ready got=%b exp=0", pc_ready); end
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin bad++; $display("FAIL rst_imem got=%b/%h exp=0/0", imem_req, imem_addr); end
    total++; if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_instr !== NOP) begin bad++; $display("FAIL rst_id got=%b/%h/%h exp=0/0/%h", id_valid, id_pc, id_instr, NOP); end
    step(); rst = 1'b0; #1;
    total++; if (pc_ready !== 1'b1 || imem_addr !== 32'd7) begin bad++; $display("FAIL rst_first_issue got=%b/%h exp=1/7", pc_ready, imem_addr); end
    step(); pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hA7;
    step(); imem_rvalid = 1'b0; pc_in = 32'd8; pc_valid = 1'b1; #1;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'd7 || id_instr !== 32'hA7) begin bad++; $display("FAIL rst_entry got=%b/%h/%h exp=1/7/a7", id_valid, id_pc, id_instr); end
    step(); pc_valid = 1'b0;
    rst = 1'b1; #1;
    total++; if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_instr !== NOP || pc_ready !== 1'b0) begin bad++; $display("FAIL rst_midwait got=%b/%h/%h/%b exp=0/0/%h/0", id_valid, id_pc, id_instr, pc_ready, NOP); end
    step(); rst = 1'b0;
    step(); imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    step(); imem_rvalid = 1'b0; #1;
    total++; if (id_valid !== 1'b0 || id_instr !== NOP) begin bad++; $display("FAIL rst_stray_rvalid got=%b/%h exp=0/%h", id_valid, id_instr, NOP); end
  endtask

  task automatic test_streaming();
    id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc_in = i; pc_valid = 1'b1; imem_rvalid = 1'b0; #1;
      total++; if (pc_ready !== 1'b1 || imem_req !== 1'b1 || imem_addr !== i) begin bad++; $display("FAIL stream_issue%0d got=%b/%b/%h exp=1/1/%h", i, pc_ready, imem_req, imem_addr, i); end
      if (i > 0) begin
        total++; if (id_valid !== 1'b1 || id_pc !== i - 1 || id_instr !== 32'h100 + i - 1) begin bad++; $display("FAIL stream_out%0d got=%b/%h/%h exp=1/%h/%h", i - 1, id_valid, id_pc, id_instr, i - 1, 32'h100 + i - 1); end
      end
      step(); imem_rvalid = 1'b1; imem_rdata = 32'h100 + i; #1;
      total++; if (pc_ready !== 1'b0 || imem_addr !== 32'd0) begin bad++; $display("FAIL stream_gap%0d got=%b/%h exp=0/0", i, pc_ready, imem_addr); end
      step();
    end
    pc_valid = 1'b0; imem_rvalid = 1'b0; #1;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'd3 || id_instr !== 32'h103) begin bad++; $display("FAIL stream_out3 got=%b/%h/%h exp=1/3/103", id_valid, id_pc, id_instr); end
    step();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b exp=0", id_valid); end
    id_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0; pc_in = 32'h10; pc_valid = 1'b1; #1;
    total++; if (pc_ready !== 1'b1) begin bad++; $display("FAIL bp_issue0 got=%b exp=1", pc_ready); end
    step(); imem_rvalid = 1'b1; imem_rdata = 32'h210;
    step(); imem_rvalid = 1'b0; pc_in = 32'h11; #1;
    total++; if (pc_ready !== 1'b1) begin bad++; $display("FAIL bp_issue1 got=%b exp=1", pc_ready); end
    step(); imem_rvalid = 1'b1; imem_rdata = 32'h211;
    step(); imem_rvalid = 1'b0; pc_in = 32'h12; #1;
    total++; if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL bp_full_block got=%b/%b exp=0/0", pc_ready, imem_req); end
    step();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || id_instr !== 32'h210 || pc_ready !== 1'b0) begin bad++; $display("FAIL bp_hold got=%b/%h/%h/%b exp=1/10/210/0", id_valid, id_pc, id_instr, pc_ready); end
    id_ready = 1'b1; #1;
    total++; if (pc_ready !== 1'b0) begin bad++; $display("FAIL bp_pop_cycle got=%b exp=0", pc_ready); end
    step(); id_ready = 1'b0; #1;
    total++; if (pc_ready !== 1'b1 || imem_addr !== 32'h12 || id_pc !== 32'h11) begin bad++; $display("FAIL bp_issue2 got=%b/%h/%h exp=1/12/11", pc_ready, imem_addr, id_pc); end
    step(); pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h212;
    step(); imem_rvalid = 1'b0; id_ready = 1'b1; #1;
    total++; if (id_pc !== 32'h11 || id_instr !== 32'h211) begin bad++; $display("FAIL bp_order0 got=%h/%h exp=11/211", id_pc, id_instr); end
    step();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'h12 || id_instr !== 32'h212) begin bad++; $display("FAIL bp_order1 got=%b/%h/%h exp=1/12/212", id_valid, id_pc, id_instr); end
    step();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", id_valid); end
    id_ready = 1'b0;
  endtask

  task automatic test_flush_outstanding();
    pc_in = 32'd5; pc_valid = 1'b1;
    step(); pc_valid = 1'b0; flush = 1'b1; #1;
    total++; if (pc_ready !== 1'b0) begin bad++; $display("FAIL fl_no_issue got=%b exp=0", pc_ready); end
    step(); flush = 1'b0;
    step(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; pc_in = 32'd20; pc_valid = 1'b1; #1;
    total++; if (pc_ready !== 1'b0) begin bad++; $display("FAIL fl_drop_ignores_pc got=%b exp=0", pc_ready); end
    step(); imem_rvalid = 1'b0; #1;
    total++; if (id_valid !== 1'b0 || id_instr !== NOP) begin bad++; $display("FAIL fl_dropped got=%b/%h exp=0/%h", id_valid, id_instr, NOP); end
    total++; if (pc_ready !== 1'b1 || imem_addr !== 32'd20) begin bad++; $display("FAIL fl_reissue got=%b/%h exp=1/14", pc_ready, imem_addr); end
    step(); pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h320;
    step(); imem_rvalid = 1'b0; #1;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'd20 || id_instr !== 32'h320) begin bad++; $display("FAIL fl_next_fetch got=%b/%h/%h exp=1/14/320", id_valid, id_pc, id_instr); end
    id_ready = 1'b1; step(); id_ready = 1'b0;
  endtask

  task automatic test_flush_coincident();
    pc_in = 32'd40; pc_valid = 1'b1;
    step(); pc_valid = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBAD;
    step(); flush = 1'b0; imem_rvalid = 1'b0; pc_in = 32'd41; pc_valid = 1'b1; #1;
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL flc_discard got=%b exp=0", id_valid); end
    total++; if (pc_ready !== 1'b1) begin bad++; $display("FAIL flc_idle got=%b exp=1", pc_ready); end
    step(); pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h441;
    step(); imem_rvalid = 1'b0; pc_in = 32'd42; pc_valid = 1'b1;
    step(); pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h442;
    step(); imem_rvalid = 1'b0; pc_in = 32'd50; pc_valid = 1'b1; #1;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'd41 || pc_ready !== 1'b0) begin bad++; $display("FAIL flc_full got=%b/%h/%b exp=1/29/0", id_valid, id_pc, pc_ready); end
    flush = 1'b1;
    step(); flush = 1'b0; #1;
    total++; if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_instr !== NOP) begin bad++; $display("FAIL flc_full_clear got=%b/%h/%h exp=0/0/%h", id_valid, id_pc, id_instr, NOP); end
    total++; if (pc_ready !== 1'b1 || imem_addr !== 32'd50) begin bad++; $display("FAIL flc_after_full got=%b/%h exp=1/32", pc_ready, imem_addr); end
    step(); pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h550;
    step(); imem_rvalid = 1'b0; #1;
    total++; if (id_pc !== 32'd50 || id_instr !== 32'h550) begin bad++; $display("FAIL flc_next got=%h/%h exp=32/550", id_pc, id_instr); end
    id_ready = 1'b1; step(); id_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    pc_in = 32'd60; pc_valid = 1'b1;
    step(); pc_valid = 1'b0;
    step(); step(); imem_rvalid = 1'b1; imem_rdata = 32'h660;
    step(); imem_rvalid = 1'b0; pc_in = 32'd61; pc_valid = 1'b1;
    step(); pc_valid = 1'b0;
    step(); step(); imem_rvalid = 1'b1; imem_rdata = 32'h661; id_ready = 1'b1; #1;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'd60 || id_instr !== 32'h660) begin bad++; $display("FAIL pp_head got=%b/%h/%h exp=1/3c/660", id_valid, id_pc, id_instr); end
    step(); imem_rvalid = 1'b0; id_ready = 1'b0; pc_in = 32'd62; pc_valid = 1'b1; #1;
    total++; if (id_valid !== 1'b1 || id_pc !== 32'd61 || id_instr !== 32'h661) begin bad++; $display("FAIL pp_after got=%b/%h/%h exp=1/3d/661", id_valid, id_pc, id_instr); end
    total++; if (pc_ready !== 1'b1) begin bad++; $display("FAIL pp_count1 got=%b exp=1", pc_ready); end
    step(); pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h662;
    step(); imem_rvalid = 1'b0; id_ready = 1'b1; #1;
    total++; if (id_pc !== 32'd61) begin bad++; $display("FAIL pp_seq0 got=%h exp=3d", id_pc); end
    step();
    total++; if (id_valid !== 1'b1 || id_pc !== 32'd62 || id_instr !== 32'h662) begin bad++; $display("FAIL pp_seq1 got=%b/%h/%h exp=1/3e/662", id_valid, id_pc, id_instr); end
    step();
    total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%b exp=0", id_valid); end
    id_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_outstanding();
    test_flush_coincident();
    test_push_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the PC register; consumes the PC it produces and feeds the ID stage.
- Issues one word-addressed request per accepted PC to instruction memory and tolerates variable read latency.
- Buffers {pc, instr} pairs in a small FIFO so an ID stall does not lose fetched words.
- Drives back-pressure to the PC stage (pc_ready → PCWrite) and discards wrong-path fetches on flush.

Parameters:
- DEPTH, 2, FIFO entries; power of 2, ≥2.
- PC_W, 32, PC width; word address, PC advances by 1.
- INSTR_W, 32, instruction width.
- NOP_INSTR, 32'h00000013, word presented on id_instr when the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_in  in  PC_W  current PC from the PC stage.
- pc_valid  in  1  pc_in is meaningful.
- pc_ready  out  1  fetch accepted this cycle; PC stage may advance (feeds PCWrite).
- imem_req  out  1  instruction memory read strobe, one cycle per request.
- imem_addr  out  PC_W  word address; equals pc_in when imem_req=1.
- imem_rvalid  in  1  read data valid; ≥1 cycle after imem_req.
- imem_rdata  in  INSTR_W  read data.
- flush  in  1  branch/jump redirect from control; kills all queued and in-flight fetches.
- id_valid  out  1  queue head is valid.
- id_ready  in  1  ID stage consumes head (0 = hazard stall).
- id_pc  out  PC_W  PC of head entry.
- id_instr  out  INSTR_W  instruction of head entry, or NOP_INSTR when id_valid=0.

Behaviour:
- Reset (async, rst=1): FSM=IDLE, count=0, pointers=0, pc_ready=0, imem_req=0, imem_addr=0, id_valid=0, id_pc=0, id_instr=NOP_INSTR.
- FSM states: IDLE (no request outstanding), WAIT (one request outstanding, response kept), DROP (one request outstanding, response discarded).
- Issue rule: in IDLE with pc_valid=1, flush=0 and count<DEPTH, assert imem_req=1 and pc_ready=1 in the same cycle (combinational). Latch pc_in as pending_pc; go to WAIT.
- At most one outstanding request. Slot reservation: count plus the outstanding request never exceeds DEPTH, so a push never overflows.
- WAIT, imem_rvalid=1, flush=0: push {pending_pc, imem_rdata}; go to IDLE. Back-to-back issue is allowed in the next cycle, giving one fetch per 2 cycles at 1-cycle memory latency.
- Pop: id_valid && id_ready removes the head.
- Simultaneous push and pop: count unchanged, both pointers advance. A push into an empty queue is visible on id_* the following cycle; there is no bypass.
- Flush (highest priority):
  - count←0 and pointers reset; id_valid=0 next cycle.
  - No issue in the flush cycle (pc_ready=0).
  - WAIT→DROP, unless imem_rvalid=1 in the same cycle, in which case that response is discarded and the FSM goes to IDLE.
  - DROP + flush stays DROP.
- DROP: ignore pc_valid. On imem_rvalid=1, discard the data and go to IDLE.
- imem_rvalid in IDLE is a protocol error: ignored, no push.
- id_pc/id_instr hold stable while id_valid=1 and id_ready=0.
- Pointer wrap: modulo DEPTH. count width is clog2(DEPTH)+1.

Decomposition:
- Shared package holds NOP_INSTR, the FSM state enum (IDLE/WAIT/DROP, 2 bits) and the fetch-entry struct {pc, instr}.
- One sub-module: if_fifo (sync FIFO; push/pop/clear, count, head data), reusable by later pipeline buffers.
- FSM and issue logic stay in the top.

Test Plan:
- Reset: rst pulsed mid-WAIT with count=1 → all outputs at reset values immediately; after release, the next response is ignored (IDLE) and id_instr=32'h00000013.
- Streaming: pc_in=0,1,2,3 with 1-cycle latency, id_ready=1 → id_pc 0,1,2,3 in order with the matching rdata; pc_ready pulses every 2nd cycle.
- Back-pressure: id_ready=0, issue 3 PCs → 2 entries stored, pc_ready=0 after the 2nd fetch. Release id_ready → 3rd fetch issues; order preserved.
- Flush while outstanding: issue pc=5, flush next cycle, rvalid 2 cycles later with 32'hDEADBEEF → never appears on id_*; next pc=20 fetch delivers id_pc=20.
- Flush with coincident rvalid, and flush with a full queue → queue empty next cycle, id_valid=0, FSM IDLE, response discarded.
- Push+pop same cycle at count=1 with 3-cycle latency → count stays 1, no lost or duplicated entry.
